// File: rtl/sfifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: read-side state encoding and
// a counter-width helper.
package sfifo_burst_reader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

    // One extra bit so a counter can hold its own limit value without wrapping.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sfifo_burst_reader_if.sv
// Valid/ready burst stream between the FIFO burst reader (master) and its
// downstream consumer (slave).
interface sfifo_burst_reader_if #(
    parameter int DWIDTH = 64
);
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/sfifo_burst_reader_burst_out_stage.sv
// Registered valid/ready output slot: takes a beat when loaded, holds it
// until accepted, and reports when it can take the next one.
module burst_out_stage #(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              last_o,
    output logic              free_o
);
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DWIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (ready_i) begin
            // Data is left in place after acceptance; only the qualifiers drop.
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
endmodule

// File: rtl/sfifo_burst_reader.sv
// Drains a first-word-fall-through FIFO into bursts of up to BURST_LEN beats.
// Optional SFIFO_BURST_READER_STATS_EN adds word/burst transfer counters.
//
//   state | meaning
//   IDLE  | hold register empty, waiting for a FIFO word
//   HOLD  | hold register full, deciding m_last before it moves to the output
module sfifo_burst_reader
    import sfifo_burst_reader_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              flush,
    sfifo_burst_reader_if.master m_if,
    output logic              busy
`ifdef SFIFO_BURST_READER_STATS_EN
    ,
    output logic [31:0]       stat_bursts,
    output logic [31:0]       stat_words
`endif
);
    localparam int unsigned BW = cnt_w(BURST_LEN);
    localparam int unsigned TW = cnt_w(TIMEOUT);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]        state_q, state_d;
    logic [DWIDTH-1:0] pend_q, pend_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              flush_q, flush_d;

    logic              in_hold, close, advance, pop, out_free, to_sat;
    logic              out_valid, out_last;
    logic [DWIDTH-1:0] out_data;

    assign in_hold = (state_q == ST_HOLD);
    assign to_sat  = (to_cnt_q == TW'(TIMEOUT - 1));
    assign close   = in_hold & ((beat_cnt_q == BW'(BURST_LEN - 1)) | flush_q | (to_sat & fifo_empty));
    assign advance = in_hold & out_free & (close | ~fifo_empty);
    // Gated by rst so the FIFO is never popped while the reader is held in reset.
    assign pop        = ~rst & ~fifo_empty & (~in_hold | advance);
    assign fifo_rd_en = pop;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        flush_d    = flush_q;
        if (pop) begin
            pend_d  = fifo_dout;
            state_d = ST_HOLD;
        end else if (advance) begin
            state_d = ST_IDLE;
        end
        if (advance) beat_cnt_d = close ? '0 : beat_cnt_q + BW'(1);
        if (pop || advance) to_cnt_d = '0;
        else if (in_hold && fifo_empty && !to_sat) to_cnt_d = to_cnt_q + TW'(1);
        // A flush arriving with nothing to close is dropped; one landing on a closing beat is absorbed.
        if (advance && close) flush_d = 1'b0;
        else if (flush && (in_hold || beat_cnt_q != '0)) flush_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            flush_q    <= flush_d;
        end
    end

    burst_out_stage #(.DWIDTH(DWIDTH)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (advance),
        .data_i  (pend_q),
        .last_i  (close),
        .ready_i (m_if.m_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last),
        .free_o  (out_free)
    );

    assign m_if.m_valid = out_valid;
    assign m_if.m_data  = out_data;
    assign m_if.m_last  = out_last;
    assign busy         = in_hold | out_valid;

`ifdef SFIFO_BURST_READER_STATS_EN
    logic [31:0] stat_bursts_q, stat_words_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts_q <= '0;
            stat_words_q  <= '0;
        end else if (out_valid && m_if.m_ready) begin
            stat_words_q <= stat_words_q + 32'd1;
            if (out_last) stat_bursts_q <= stat_bursts_q + 32'd1;
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_words  = stat_words_q;
`endif
endmodule

// File: tb/tb_sfifo_burst_reader.sv
// Bench for sfifo_burst_reader: behavioural FIFO, beat monitor and a burst-framing
// reference model; define SFIFO_BURST_READER_STATS_EN to also check the counters.
module tb_sfifo_burst_reader;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          flush;
    logic          busy;
`ifdef SFIFO_BURST_READER_STATS_EN
    logic [31:0]   stat_bursts, stat_words;
`endif

    sfifo_burst_reader_if #(.DWIDTH(DW)) m_if();

    sfifo_burst_reader #(.DWIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_if       (m_if),
        .busy       (busy)
`ifdef SFIFO_BURST_READER_STATS_EN
        ,
        .stat_bursts(stat_bursts),
        .stat_words (stat_words)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Behavioural first-word-fall-through FIFO.
    logic [DW-1:0] fq[$];

    function automatic void fifo_refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endfunction

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_refresh();
    endtask

    always begin : fifo_pop
        bit pop_s;
        @(negedge clk);
        pop_s = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop_s && fq.size() > 0) begin
            void'(fq.pop_front());
            fifo_refresh();
        end
    end

    // Beat monitor plus per-cycle protocol checks.
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } beat_t;
    beat_t beats[$];

    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            vectors++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_en_when_empty cyc=%0d: fifo_rd_en=%b with fifo_empty=%b, required 0", cyc, fifo_rd_en, fifo_empty);
            end
            if (pv && !pr) begin
                vectors++;
                if (m_if.m_valid !== 1'b1 || m_if.m_data !== pd || m_if.m_last !== pl) begin
                    errors++;
                    $display("FAIL stall_stable cyc=%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             cyc, m_if.m_valid, m_if.m_data, m_if.m_last, pd, pl);
                end
            end
            if (m_if.m_valid && m_if.m_ready) beats.push_back('{d: m_if.m_data, l: m_if.m_last, c: cyc});
            pv = m_if.m_valid;
            pr = m_if.m_ready;
            pd = m_if.m_data;
            pl = m_if.m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        m_if.m_ready = 1'b0;
        fifo_refresh();
        push(32'hdead_beef);
        repeat (2) @(posedge clk);
        #2;
        vectors += 5;
        if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", m_if.m_valid); end
        if (m_if.m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", m_if.m_last); end
        if (m_if.m_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", m_if.m_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
        fq.delete();
        fifo_refresh();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_burst_seq();
        beats.delete();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(DW'(i));
        wait_beats(8, 60);
        vectors++;
        if (beats.size() != 8) begin errors++; $display("FAIL seq_count: got %0d beats, required 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            vectors += 2;
            if (beats[i].d !== DW'(i)) begin errors++; $display("FAIL seq_data[%0d]: got %h, required %h", i, beats[i].d, DW'(i)); end
            if (beats[i].l !== ((i % BL) == BL - 1)) begin errors++; $display("FAIL seq_last[%0d]: got %b, required %b", i, beats[i].l, (i % BL) == BL - 1); end
            if (i > 0) begin
                vectors++;
                if (beats[i].c - beats[i-1].c != 1) begin errors++; $display("FAIL seq_bubble[%0d]: gap %0d cycles, required 1", i, beats[i].c - beats[i-1].c); end
            end
        end
        repeat (TO + 4) tick();
        vectors++;
        if (beats.size() != 8) begin errors++; $display("FAIL seq_extra: got %0d beats, required 8", beats.size()); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] w[7];
        beats.delete();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 7; i++) w[i] = $urandom;
        for (int i = 0; i < 3; i++) push(w[i]);
        wait_beats(3, TO + 40);
        vectors++;
        if (beats.size() != 3) begin errors++; $display("FAIL to_count: got %0d beats, required 3", beats.size()); end
        else begin
            vectors += 4;
            if (beats[0].l !== 1'b0 || beats[1].l !== 1'b0) begin errors++; $display("FAIL to_early_last: got %b%b, required 00", beats[0].l, beats[1].l); end
            if (beats[2].l !== 1'b1) begin errors++; $display("FAIL to_last: got %b, required 1", beats[2].l); end
            if (beats[2].d !== w[2]) begin errors++; $display("FAIL to_data: got %h, required %h", beats[2].d, w[2]); end
            if (beats[2].c - beats[1].c != TO) begin errors++; $display("FAIL to_delay: got %0d cycles, required %0d", beats[2].c - beats[1].c, TO); end
        end
        // Burst count must restart at zero after the timeout close.
        for (int i = 3; i < 7; i++) push(w[i]);
        wait_beats(7, 60);
        vectors++;
        if (beats.size() != 7) begin errors++; $display("FAIL to_restart_count: got %0d beats, required 7", beats.size()); end
        for (int i = 3; i < beats.size() && i < 7; i++) begin
            vectors++;
            if (beats[i].d !== w[i] || beats[i].l !== (i == 6)) begin
                errors++;
                $display("FAIL to_restart[%0d]: got d=%h l=%b, required d=%h l=%b", i, beats[i].d, beats[i].l, w[i], i == 6);
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp_d[6];
        logic          exp_l[6];
        exp_d = '{32'ha, 32'hb, 32'd9, 32'd10, 32'd11, 32'd12};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        beats.delete();
        m_if.m_ready = 1'b1;
        push(exp_d[0]);
        push(exp_d[1]);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_beats(2, 10);
        vectors++;
        if (beats.size() < 2) begin errors++; $display("FAIL flush_close: got %0d beats within 10 cycles, required 2", beats.size()); end
        else begin
            vectors++;
            if (beats[1].c - beats[0].c > 3) begin errors++; $display("FAIL flush_latency: got %0d cycles, required <=3", beats[1].c - beats[0].c); end
        end
        for (int i = 2; i < 6; i++) push(exp_d[i]);
        wait_beats(6, 60);
        vectors++;
        if (beats.size() != 6) begin errors++; $display("FAIL flush_count: got %0d beats, required 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            vectors++;
            if (beats[i].d !== exp_d[i] || beats[i].l !== exp_l[i]) begin
                errors++;
                $display("FAIL flush_beat[%0d]: got d=%h l=%b, required d=%h l=%b", i, beats[i].d, beats[i].l, exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[12];
        int k = 0;
        beats.delete();
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            push(w[i]);
        end
        while (beats.size() < 12 && k < 200) begin
            m_if.m_ready = k[0];
            tick();
            k++;
        end
        m_if.m_ready = 1'b1;
        vectors++;
        if (beats.size() != 12) begin errors++; $display("FAIL bp_count: got %0d beats, required 12", beats.size()); end
        for (int i = 0; i < beats.size() && i < 12; i++) begin
            vectors++;
            if (beats[i].d !== w[i] || beats[i].l !== ((i % BL) == BL - 1)) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got d=%h l=%b, required d=%h l=%b", i, beats[i].d, beats[i].l, w[i], (i % BL) == BL - 1);
            end
        end
    endtask

    // Reference: a burst closes at BURST_LEN beats or when the FIFO then stays empty past the timeout.
    task automatic test_random_gaps();
        localparam int N = 16;
        logic [DW-1:0] exp_d[N];
        logic          exp_l[N];
        int            pos = 0;
        bit            long_gap;
        beats.delete();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_d[i] = $urandom;
            long_gap = ($urandom_range(0, 3) == 0) || (i == N - 1);
            exp_l[i] = (pos == BL - 1) || long_gap;
            pos = exp_l[i] ? 0 : pos + 1;
            push(exp_d[i]);
            repeat (long_gap ? TO + 6 : int'($urandom_range(0, 2))) tick();
        end
        wait_beats(N, 40);
        vectors++;
        if (beats.size() != N) begin errors++; $display("FAIL gap_count: got %0d beats, required %0d", beats.size(), N); end
        for (int i = 0; i < beats.size() && i < N; i++) begin
            vectors++;
            if (beats[i].d !== exp_d[i] || beats[i].l !== exp_l[i]) begin
                errors++;
                $display("FAIL gap_beat[%0d]: got d=%h l=%b, required d=%h l=%b", i, beats[i].d, beats[i].l, exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] w[4];
        beats.delete();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push($urandom);
        repeat (3) tick();
        m_if.m_ready = 1'b0;
        tick();
        vectors++;
        if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, required 1", m_if.m_valid); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors += 4;
        if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, required 0", m_if.m_valid); end
        if (m_if.m_last !== 1'b0) begin errors++; $display("FAIL async_last: got %b, required 0", m_if.m_last); end
        if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b, required 0", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL async_rd_en: got %b, required 0", fifo_rd_en); end
        tick();
        fq.delete();
        fifo_refresh();
        tick();
        rst = 1'b0;
        m_if.m_ready = 1'b1;
        beats.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push(w[i]);
        end
        wait_beats(4, 40);
        vectors++;
        if (beats.size() != 4) begin errors++; $display("FAIL post_reset_count: got %0d beats, required 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            vectors++;
            if (beats[i].d !== w[i] || beats[i].l !== (i == 3)) begin
                errors++;
                $display("FAIL post_reset[%0d]: got d=%h l=%b, required d=%h l=%b", i, beats[i].d, beats[i].l, w[i], i == 3);
            end
        end
    endtask

`ifdef SFIFO_BURST_READER_STATS_EN
    task automatic test_stats();
        localparam int NW = 10;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        beats.delete();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < NW; i++) push($urandom);
        wait_beats(NW, TO + 60);
        tick();
        vectors += 2;
        if (stat_words !== 32'(NW)) begin errors++; $display("FAIL stat_words: got %0d, required %0d", stat_words, NW); end
        if (stat_bursts !== 32'((NW + BL - 1) / BL)) begin errors++; $display("FAIL stat_bursts: got %0d, required %0d", stat_bursts, (NW + BL - 1) / BL); end
    endtask
`endif

    initial begin
        test_reset();
        test_burst_seq();
        test_timeout();
        test_flush();
        test_backpressure();
        test_random_gaps();
        test_async_reset();
`ifdef SFIFO_BURST_READER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
